// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry for the LC-3b L1 data cache.
package l1_dcache_pkg;

    localparam int DC_S_INDEX  = 3;
    localparam int DC_OFFSET_W = 4;
    localparam int DC_TAG_W    = 16 - DC_OFFSET_W - DC_S_INDEX;

    typedef logic [127:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_WRITEBACK,
        DC_ALLOCATE
    } lc3b_dcache_state;

endpackage

// File: rtl/l1_dcache_way.sv
// One cache way: valid/dirty/tag/data arrays, async read by index,
// synchronous line load and byte-masked 16-bit word write.
module l1_dcache_way
    import l1_dcache_pkg::*;
#(
    parameter int S_INDEX = DC_S_INDEX,
    parameter int TAG_W   = DC_TAG_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [S_INDEX-1:0]   index,
    input  logic                 load,
    input  logic [TAG_W-1:0]     load_tag,
    input  lc3b_cache_line       load_line,
    input  logic                 word_we,
    input  logic [2:0]           lane,
    input  logic [1:0]           byte_en,
    input  logic [15:0]          wdata,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_W-1:0]     tag,
    output lc3b_cache_line       line
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q [SETS];
    lc3b_cache_line   data_q [SETS];

    // Only the status bits are reset; tag and data contents are don't-care until valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (load) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            tag_q[index]  <= load_tag;
            data_q[index] <= load_line;
        end else if (word_we) begin
            if (byte_en[0]) data_q[index][{lane, 4'd0} +: 8] <= wdata[7:0];
            if (byte_en[1]) data_q[index][{lane, 4'd8} +: 8] <= wdata[15:8];
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];

endmodule

// File: rtl/l1_dcache.sv
// 2-way set-associative write-back, write-allocate L1 data cache for the
// LC-3b MEM stage; 0-cycle hits, 128-bit line fills and victim write-backs.
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int S_INDEX = DC_S_INDEX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int TAG_W = 16 - DC_OFFSET_W - S_INDEX;
    localparam int SETS  = 1 << S_INDEX;

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [2:0]         lane;
    logic               unused_addr_bit;

    assign req_tag         = mem_address[15 -: TAG_W];
    assign req_index       = mem_address[DC_OFFSET_W +: S_INDEX];
    assign lane            = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    lc3b_dcache_state state, state_next;
    logic [SETS-1:0]  lru;
    logic [1:0]       way_valid, way_dirty, way_hit, way_load, way_we;
    logic [TAG_W-1:0] way_tag [2];
    lc3b_cache_line   way_line [2];
    logic             req, hit, hit_way, victim, lru_update;

    for (genvar w = 0; w < 2; w++) begin : g_way
        l1_dcache_way #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_way (
            .clk       (clk),
            .reset     (reset),
            .index     (req_index),
            .load      (way_load[w]),
            .load_tag  (req_tag),
            .load_line (pmem_rdata),
            .word_we   (way_we[w]),
            .lane      (lane),
            .byte_en   (mem_byte_enable),
            .wdata     (mem_wdata),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .line      (way_line[w])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    assign req     = mem_read | mem_write;
    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    // Fill an empty way before displacing anything; otherwise evict the LRU way.
    always_comb begin
        if (!way_valid[0])      victim = 1'b0;
        else if (!way_valid[1]) victim = 1'b1;
        else                    victim = lru[req_index];
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        way_load     = '0;
        way_we       = '0;
        lru_update   = 1'b0;
        unique case (state)
            DC_IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp        = 1'b1;
                        lru_update      = 1'b1;
                        way_we[hit_way] = mem_write;
                    end else if (way_valid[victim] && way_dirty[victim]) begin
                        state_next = DC_WRITEBACK;
                    end else begin
                        state_next = DC_ALLOCATE;
                    end
                end
            end
            DC_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {way_tag[victim], req_index, 4'b0000};
                pmem_wdata   = way_line[victim];
                if (pmem_resp) state_next = DC_ALLOCATE;
            end
            DC_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, 4'b0000};
                if (pmem_resp) begin
                    way_load[victim] = 1'b1;
                    state_next       = DC_IDLE;
                end
            end
            default: state_next = DC_IDLE;
        endcase
    end

    assign mem_rdata = mem_resp ? way_line[hit_way][{lane, 4'd0} +: 16] : 16'h0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DC_IDLE;
            lru   <= '0;
        end else begin
            state <= state_next;
            if (lru_update) lru[req_index] <= ~hit_way;
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: architectural memory + LRU residency model,
// randomized physical-memory latency, directed corner cases and random traffic.
module tb_l1_dcache;

    logic         clk;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit is_rd; logic [15:0] data; } sb_t;
    typedef struct { bit is_wr; logic [15:0] addr; } pop_t;

    int checks;
    int failures;
    sb_t  sb_q[$];
    pop_t pexp[$];

    // Physical memory contents and the architectural (program-visible) word view.
    logic [127:0] pm [int];
    logic [15:0]  ref_w [int];
    // Cache residency: line number -> last-use stamp, plus dirty flag.
    int res_stamp [int];
    bit res_dirty [int];
    int now_t;
    bit resp_en;
    int wait_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat_line(input int line);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = 16'((line * 8 + w) * 40503) ^ 16'h5A5A;
        return l;
    endfunction

    function automatic logic [127:0] pm_line(input int line);
        if (pm.exists(line)) return pm[line];
        return pat_line(line);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        logic [127:0] l;
        int wa;
        wa = int'(a >> 1);
        if (ref_w.exists(wa)) return ref_w[wa];
        l = pm_line(int'(a >> 4));
        return l[int'(a[3:1]) * 16 +: 16];
    endfunction

    function automatic logic [127:0] ref_line(input int line);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = ref_read(16'(line * 16 + w * 2));
        return l;
    endfunction

    function automatic void model_reset();
        res_stamp.delete();
        res_dirty.delete();
        ref_w.delete();
        sb_q.delete();
        pexp.delete();
        wait_cnt = 0;
    endfunction

    // Predict hit/miss and the physical-memory traffic a request must cause.
    task automatic model_access(input logic [15:0] a, input bit wr, input logic [1:0] be,
                                input logic [15:0] wd, output bit hit);
        int line, set, cnt, vic, best;
        logic [15:0] w;
        pop_t op;
        line = int'(a >> 4);
        set  = line & 7;
        hit  = res_stamp.exists(line);
        if (!hit) begin
            cnt = 0; vic = -1; best = 0;
            foreach (res_stamp[l]) begin
                if ((l & 7) == set) begin
                    cnt++;
                    if (vic < 0 || res_stamp[l] < best) begin vic = l; best = res_stamp[l]; end
                end
            end
            if (cnt >= 2) begin
                if (res_dirty[vic]) begin
                    op.is_wr = 1'b1; op.addr = 16'(vic * 16);
                    pexp.push_back(op);
                end
                res_stamp.delete(vic);
                res_dirty.delete(vic);
            end
            op.is_wr = 1'b0; op.addr = 16'(line * 16);
            pexp.push_back(op);
            res_dirty[line] = 1'b0;
        end
        now_t++;
        res_stamp[line] = now_t;
        if (wr) begin
            res_dirty[line] = 1'b1;
            w = ref_read(a);
            if (be[0]) w[7:0]  = wd[7:0];
            if (be[1]) w[15:8] = wd[15:8];
            ref_w[int'(a >> 1)] = w;
        end
    endtask

    task automatic do_req(input logic [15:0] a, input bit rd, input bit wr,
                          input logic [1:0] be, input logic [15:0] wd);
        bit  hit;
        int  cyc;
        sb_t e;
        e.is_rd = rd && !wr;
        e.data  = ref_read(a);
        model_access(a, wr, be, wd, hit);
        sb_q.push_back(e);
        mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
        cyc = 0;
        @(negedge clk);
        while (!mem_resp && cyc < 100) begin cyc++; @(negedge clk); end
        if (!mem_resp) begin
            checks++; failures++;
            $display("FAIL req_timeout addr=%h waited=%0d cycles", a, cyc);
        end else begin
            chk("hit_latency", 128'(cyc == 0), 128'(hit));
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", 128'(mem_resp), 128'(0));
        chk("rst_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
        model_reset();
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every mem_resp must match the oldest outstanding request.
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            if (mem_resp) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp addr=%h rdata=%h", mem_address, mem_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_rd) chk("rdata", 128'(mem_rdata), 128'(e.data));
                end
            end else begin
                chk("rdata_idle", 128'(mem_rdata), 128'(0));
            end
        end
    end

    // Physical memory responder with random latency; checks each transaction it serves.
    initial begin
        pop_t op;
        int   line;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!resp_en || !reset || !(pmem_read || pmem_write)) continue;
            if (wait_cnt > 0) begin wait_cnt--; continue; end
            wait_cnt = $urandom_range(0, 2);
            line = int'(pmem_address >> 4);
            if (pexp.size() == 0) begin
                checks++; failures++;
                $display("FAIL pmem_unexpected addr=%h rd=%0d wr=%0d", pmem_address, pmem_read, pmem_write);
            end else begin
                op = pexp.pop_front();
                chk("pmem_op", 128'({pmem_write, pmem_read}), 128'(op.is_wr ? 2'b10 : 2'b01));
                chk("pmem_addr", 128'(pmem_address), 128'(op.addr));
            end
            if (pmem_write) begin
                chk("wb_data", pmem_wdata, ref_line(line));
                pm[line] = ref_line(line);
            end else begin
                pmem_rdata = pm_line(line);
            end
            pmem_resp = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit           hit;
        int           cyc;
        logic [127:0] l;
        logic [15:0]  a;
        int           r;
        checks = 0; failures = 0; now_t = 0; wait_cnt = 0;
        resp_en = 1'b1;
        reset = 1'b0;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        @(posedge clk); #1;
        do_reset();

        // Cold read fills 0x0040 with BEEF in word 3, then a 0-cycle hit; byte store merge.
        l = pat_line(4);
        l[63:48] = 16'hBEEF;
        pm[4] = l;
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0046, 1'b0, 1'b1, 2'b01, 16'h1234);
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000);

        // Dirty victim in set 4: write-back of 0x0040 before allocating 0x1040.
        do_reset();
        do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0840, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0042, 1'b0, 1'b1, 2'b11, 16'hA5C3);
        do_req(16'h0840, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h1040, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0042, 1'b1, 1'b0, 2'b00, 16'h0000);

        // Clean victim: direct allocate; LRU follows each hit; zero byte-enable store.
        do_reset();
        do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0840, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0840, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h1040, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h0840, 1'b1, 1'b0, 2'b00, 16'h0000);
        do_req(16'h084E, 1'b1, 1'b1, 2'b00, 16'hFFFF);
        do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);

        // Reset asserted while ALLOCATE is pending: transfer abandoned, line not valid.
        do_reset();
        resp_en = 1'b0;
        mem_address = 16'h0046; mem_read = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!pmem_read && cyc < 20) begin cyc++; @(negedge clk); end
        chk("rst_alloc_read", 128'(pmem_read), 128'(1));
        chk("rst_alloc_addr", 128'(pmem_address), 128'(16'h0040));
        #2 reset = 1'b0;
        #1;
        chk("rst_async_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_async_pmem_addr", 128'(pmem_address), 128'(0));
        mem_read = 1'b0;
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        resp_en = 1'b1;
        @(posedge clk); #1;
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000);

        // Request withdrawn mid-fill: line still installed, no response, later hit.
        do_reset();
        resp_en = 1'b0;
        model_access(16'h2236, 1'b0, 2'b00, 16'h0000, hit);
        mem_address = 16'h2236; mem_read = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!pmem_read && cyc < 20) begin cyc++; @(negedge clk); end
        chk("drop_fill_start", 128'(pmem_read), 128'(1));
        @(posedge clk); #1;
        mem_read = 1'b0;
        resp_en = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (pmem_read && cyc < 20) begin cyc++; @(negedge clk); end
        chk("drop_fill_done", 128'(pmem_read), 128'(0));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        do_req(16'h2236, 1'b1, 1'b0, 2'b00, 16'h0000);

        // Random traffic over a few conflicting tags in two sets.
        for (int i = 0; i < 300; i++) begin
            a = {9'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd5,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            r = $urandom_range(0, 9);
            do_req(a, r < 5 || r == 9, r >= 5, 2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", 128'(sb_q.size()), 128'(0));
        chk("pmem_drain", 128'(pexp.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
